ahci_fis_dispatch: RTL

Receive-side FIS dispatcher, directly upstream of the FIS receiver on the control side. When the receiver reports a valid FIS header (`fis_first_vld`), this block decodes the FIS type byte and issues exactly one `get_*` command pulse to the receiver. It then waits for completion and reports a single classified done event to the port command FSM. It also supervises the receiver with a watchdog and latches fatal conditions.

---
 rtl/ahci_fis_dispatch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ahci_fis_dispatch.sv
// Receive-side FIS dispatcher: decodes the FIS type of each header, issues one
// get_* command to the receiver, supervises it with a watchdog and reports completion.
module ahci_fis_dispatch #(
   parameter int TIMEOUT_BITS = 16
) (
   input  logic        mclk,
   input  logic        hba_rst_n,
   input  logic        en,
   input  logic        fis_first_vld,
   input  logic [7:0]  fis_type,
   input  logic        sig_pending,
   input  logic        data_fis_allowed,
   output logic        get_sig,
   output logic        get_dsfis,
   output logic        get_psfis,
   output logic        get_rfis,
   output logic        get_sdbfis,
   output logic        get_ufis,
   output logic        get_data_fis,
   output logic        get_ignore,
   input  logic        get_fis_busy,
   input  logic        fis_ok,
   input  logic        fis_err,
   input  logic        fis_ferr,
   output logic        fis_done,
   output logic [1:0]  fis_status,
   output logic [3:0]  fis_kind,
   output logic        dma_activate,
   output logic        halted,
   output logic [15:0] fis_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_REPORT = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   // One-hot command vector, ordered as {sig, dsfis, psfis, rfis, sdbfis, ufis, data_fis, ignore}
   localparam logic [7:0] CMD_SIG    = 8'h80;
   localparam logic [7:0] CMD_DSFIS  = 8'h40;
   localparam logic [7:0] CMD_PSFIS  = 8'h20;
   localparam logic [7:0] CMD_RFIS   = 8'h10;
   localparam logic [7:0] CMD_SDBFIS = 8'h08;
   localparam logic [7:0] CMD_UFIS   = 8'h04;
   localparam logic [7:0] CMD_DATA   = 8'h02;
   localparam logic [7:0] CMD_IGNORE = 8'h01;

   logic [2:0]              state;
   logic [7:0]              cmd_q;
   logic [3:0]              kind_q;
   logic [TIMEOUT_BITS-1:0] wd;
   logic [TIMEOUT_BITS-1:0] wd_nxt;
   logic                    cpl;
   logic                    wd_max;
   logic [1:0]              cpl_status;
   logic                    dispatch;

   function automatic logic [11:0] decode(input logic [7:0] t, input logic sp, input logic dfa);
      case (t)
         8'h34:   decode = sp  ? {4'd2, CMD_SIG}  : {4'd1, CMD_RFIS};
         8'h41:   decode = {4'd3, CMD_DSFIS};
         8'h5F:   decode = {4'd4, CMD_PSFIS};
         8'hA1:   decode = {4'd5, CMD_SDBFIS};
         8'h46:   decode = dfa ? {4'd6, CMD_DATA} : {4'd9, CMD_IGNORE};
         8'h39:   decode = {4'd7, CMD_IGNORE};
         default: decode = {4'd8, CMD_UFIS};
      endcase
   endfunction

   assign {get_sig, get_dsfis, get_psfis, get_rfis,
           get_sdbfis, get_ufis, get_data_fis, get_ignore} = cmd_q;

   assign dispatch   = (state == S_IDLE) && en && fis_first_vld && !halted;
   assign wd_nxt     = wd + 1'b1;
   assign wd_max     = (wd_nxt == {TIMEOUT_BITS{1'b1}});
   assign cpl        = !get_fis_busy && (fis_ok || fis_err || fis_ferr);
   assign cpl_status = fis_ferr ? 2'd2 : (fis_err ? 2'd1 : 2'd0);

   // Control path: state, command pulses and reported results
   always_ff @(posedge mclk) begin
      if (!hba_rst_n) begin
         state        <= S_IDLE;
         cmd_q        <= '0;
         fis_done     <= 1'b0;
         fis_status   <= 2'd0;
         fis_kind     <= 4'd0;
         dma_activate <= 1'b0;
         halted       <= 1'b0;
         fis_count    <= 16'd0;
      end else begin
         cmd_q        <= '0;
         fis_done     <= 1'b0;
         dma_activate <= 1'b0;
         case (state)
            S_IDLE: begin
               if (dispatch) begin
                  cmd_q <= decode(fis_type, sig_pending, data_fis_allowed)[7:0];
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               // A completion seen in the same cycle as the watchdog limit is honoured
               if (cpl || wd_max) begin
                  fis_status   <= cpl ? cpl_status : 2'd3;
                  fis_kind     <= kind_q;
                  fis_done     <= 1'b1;
                  fis_count    <= fis_count + 16'd1;
                  dma_activate <= cpl && (cpl_status == 2'd0) && (kind_q == 4'd7);
                  state        <= S_REPORT;
               end
            end
            S_REPORT: begin
               if (fis_status[1]) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  state  <= S_IDLE;
               end
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Data path: latched kind and watchdog counter need no reset
   always_ff @(posedge mclk) begin
      if (dispatch)
         kind_q <= decode(fis_type, sig_pending, data_fis_allowed)[11:8];
      if (state == S_ISSUE)
         wd <= '0;
      else if (state == S_WAIT)
         wd <= wd_nxt;
   end

endmodule
